eep_save_ctrl: RTL
==================

# eep_save_ctrl

Sequencer that owns the EEPROM external access port (ext_eep_*) and moves the EEPROM image between on-chip EEPROM storage and the MiSTer save-file block interface (sd_*). It sits between hps_io and the ATmega EEPROM peripheral. Its jobs:
- restore the image when a save file is mounted;
- write it back on an OSD save request, or automatically after the CPU has stopped writing EEPROM for a set time;
- hold the CPU off the EEPROM while it owns the port.

## Interface
Parameters:
- EEP_SIZE, 512: EEPROM bytes; multiple of 512. BLOCKS = EEP_SIZE/512.
- AUTOSAVE_CYCLES, 24'd8000000: clk cycles of write inactivity before autosave.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- img_mounted  in  1  one-cycle pulse when a save image is mounted.
- img_readonly  in  1  mounted image is read-only; level.
- img_size_nz  in  1  mounted image size non-zero; sampled with img_mounted.
- save_req  in  1  one-cycle OSD save pulse.
- autosave_en  in  1  enable autosave; level.
- cpu_eep_wr  in  1  pulse on every committed CPU EEPROM write.
- cpu_eep_busy  in  1  CPU EEPROM operation in progress (EEMPE/EEPE window).
- cpu_hold  out  1  CPU must not access EEPROM registers.
- busy  out  1  transfer in progress.
- dirty  out  1  EEPROM changed since last load/save.
- sd_lba  out  32  block number, 0..BLOCKS-1.
- sd_rd, sd_wr  out  1  block read/write requests.
- sd_ack  in  1  hps_io acknowledge, high for the whole block transfer.
- sd_buff_addr  in  9  byte offset in block.
- sd_buff_dout  in  8  load data.
- sd_buff_wr  in  1  load data strobe.
- sd_buff_din  out  8  save data.
- ext_eep_addr  out  17  EEPROM byte address.
- ext_eep_data_in  out  8  write data to EEPROM.
- ext_eep_data_wr  out  1  EEPROM write strobe.
- ext_eep_data_out  in  8  EEPROM read data; registered, valid 1 clk after address.
- ext_eep_data_rd, ext_eep_data_en  out  1  port read enable / port ownership.

## Operation
State flags:
- `mounted`: set by img_mounted & img_size_nz; cleared by img_mounted & !img_size_nz.
- `load_pend`: set by img_mounted & img_size_nz.
- `save_pend`: set by save_req, or by autosave timer expiry.
- Both pend flags are dropped (cleared immediately) if !mounted or img_readonly at the moment they are set.
- Load has priority over save. A save_req arriving during a transfer is kept pending.

Dirty and autosave:
- `dirty` sets on cpu_eep_wr. Cleared at end of a successful load or save.
- Autosave timer:
  - reloads to AUTOSAVE_CYCLES on cpu_eep_wr;
  - decrements while dirty & autosave_en & state==IDLE;
  - at 0 it sets save_pend and stops.

State machine:
- IDLE: if a pend flag is set and !cpu_eep_busy, go to ARB.
- ARB: assert cpu_hold. blk=0. Go to LOAD_REQ or SAVE_REQ.
- LOAD_REQ / SAVE_REQ: sd_lba=blk, sd_rd (load) or sd_wr (save) = 1. On sd_ack rise: drop the request and go to the matching XFER state.
- LOAD_XFER: on each sd_buff_wr, register ext_eep_addr={blk,sd_buff_addr}, ext_eep_data_in=sd_buff_dout, and pulse ext_eep_data_wr for 1 cycle.
- SAVE_XFER:
  - ext_eep_addr={blk,sd_buff_addr}, combinational;
  - ext_eep_data_rd=1;
  - sd_buff_din=ext_eep_data_out.
- Both XFER states: on sd_ack fall, if blk<BLOCKS-1 then blk+1 and back to REQ. Otherwise clear the pend flag and dirty, then go to IDLE.
- ext_eep_data_en=1 in all states except IDLE.
- busy = cpu_hold = (state != IDLE).

## Timing
Reset values:
- All outputs 0; state IDLE.
- Flags, blk and timer cleared.
- A reset mid-transfer abandons it: no further EEPROM writes, sd_rd/sd_wr low next cycle.

Latency:
- IDLE to ARB: 1 clk. ARB to REQ: 1 clk.
- sd_rd/sd_wr fall the cycle after sd_ack is first seen high.
- Load write reaches EEPROM 1 clk after sd_buff_wr.
- Save: sd_buff_din valid 1 clk after sd_buff_addr changes.

Boundary conditions:
- Simultaneous img_mounted and save_req: load runs first, save follows.
- cpu_eep_wr while cpu_hold is high: still sets dirty (it is a CPU-side leftover commit).
- Block count wraps never; blk is a terminal count.

## Test plan
- Mount (size!=0, rw) with a 512-byte pattern i^0x5A: ext writes at 0..511 match, sd_lba=0, dirty=0, busy falls after sd_ack falls.
- After load, CPU write pulse then save_req: sd_wr=1, bench reads 512 bytes equal to EEPROM contents (2-clk model), dirty=0 at end.
- autosave_en=1, AUTOSAVE_CYCLES=100, one cpu_eep_wr: sd_wr rises exactly 100 clk + 2 later. A second write at 50 clk defers it by 50.
- img_readonly=1 with save_req: sd_wr never asserts, dirty stays 1.
- cpu_eep_busy high when save_req arrives: state stays IDLE until busy drops, then sd_wr within 2 clk.
- rst asserted mid-LOAD_XFER at byte 200: no writes after reset, cpu_hold=0 and ext_eep_data_en=0 the next cycle.

Source files
------------

// File: rtl/eep_save_ctrl_if.sv
// eep_save_ctrl_if: bundles the two data paths owned by the save controller.
//   sd_*      : MiSTer save-file block interface toward hps_io
//               (block request/ack, byte address, load/save data).
//   ext_eep_* : external access port of the on-chip EEPROM storage
//               (address, write data/strobe, read data/enable, ownership).
// modport master : the controller side (drives requests and EEPROM port).
// modport slave  : hps_io + EEPROM side (drives ack, buffer data, read data).
interface eep_save_ctrl_if;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_din;
    logic [16:0] ext_eep_addr;
    logic [7:0]  ext_eep_data_in;
    logic        ext_eep_data_wr;
    logic [7:0]  ext_eep_data_out;
    logic        ext_eep_data_rd;
    logic        ext_eep_data_en;

    modport master (
        output sd_lba, sd_rd, sd_wr, sd_buff_din,
               ext_eep_addr, ext_eep_data_in, ext_eep_data_wr,
               ext_eep_data_rd, ext_eep_data_en,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
               ext_eep_data_out
    );

    modport slave (
        input  sd_lba, sd_rd, sd_wr, sd_buff_din,
               ext_eep_addr, ext_eep_data_in, ext_eep_data_wr,
               ext_eep_data_rd, ext_eep_data_en,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
               ext_eep_data_out
    );
endinterface

// File: rtl/eep_save_ctrl.sv
// eep_save_ctrl: moves the EEPROM image between on-chip EEPROM storage and the
// save-file block interface. Restores on mount, writes back on OSD save or
// after AUTOSAVE_CYCLES of CPU write inactivity, and holds the CPU off the
// EEPROM while it owns the external port.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   img_mounted           pulse: save image mounted
//   img_readonly          level: mounted image is read-only
//   img_size_nz           mounted image size non-zero (sampled with img_mounted)
//   save_req              pulse: OSD save request
//   autosave_en           level: enable autosave
//   cpu_eep_wr            pulse: committed CPU EEPROM write
//   cpu_eep_busy          CPU EEPROM operation in progress
//   cpu_hold, busy        controller owns the EEPROM port
//   dirty                 EEPROM changed since last load/save
//   bus                   sd_* and ext_eep_* signals (master modport)
module eep_save_ctrl #(
    parameter int          EEP_SIZE        = 512,
    parameter logic [23:0] AUTOSAVE_CYCLES = 24'd8000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  img_mounted,
    input  logic                  img_readonly,
    input  logic                  img_size_nz,
    input  logic                  save_req,
    input  logic                  autosave_en,
    input  logic                  cpu_eep_wr,
    input  logic                  cpu_eep_busy,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  dirty,
    eep_save_ctrl_if.master       bus
);
    localparam int BLOCKS = EEP_SIZE / 512;
    localparam int BW     = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;

    typedef enum logic [2:0] {
        IDLE, ARB, LOAD_REQ, SAVE_REQ, LOAD_XFER, SAVE_XFER
    } state_t;

    state_t        state;
    logic [BW-1:0] blk;
    logic          mounted;
    logic          load_pend;
    logic          save_pend;
    logic          is_load;
    logic          own;
    logic          ack_q;
    logic [23:0]   timer;
    logic          sd_rd_r;
    logic          sd_wr_r;
    logic          eep_wr_r;
    logic [16:0]   load_addr;
    logic [7:0]    load_data;

    logic          mount_nxt;
    logic          save_ok;
    logic          tmr_run;
    logic          tmr_exp;
    logic          ack_fall;
    logic          last_blk;
    logic          save_xfer;

    // A save request may arrive in the same cycle as the mount that enables
    // it, so qualify against the post-update mount state.
    assign mount_nxt = img_mounted ? img_size_nz : mounted;
    assign save_ok   = mount_nxt & ~img_readonly;
    // Timer counts down to zero and then parks there until the next CPU write.
    assign tmr_run   = dirty & autosave_en & (state == IDLE) & (timer != 24'd0);
    assign tmr_exp   = tmr_run & (timer == 24'd1);
    assign ack_fall  = ack_q & ~bus.sd_ack;
    assign last_blk  = (int'(blk) == BLOCKS - 1);
    assign save_xfer = (state == SAVE_XFER);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            blk       <= '0;
            mounted   <= 1'b0;
            load_pend <= 1'b0;
            save_pend <= 1'b0;
            is_load   <= 1'b0;
            own       <= 1'b0;
            dirty     <= 1'b0;
            ack_q     <= 1'b0;
            timer     <= '0;
            sd_rd_r   <= 1'b0;
            sd_wr_r   <= 1'b0;
            eep_wr_r  <= 1'b0;
            load_addr <= '0;
            load_data <= '0;
        end else begin
            ack_q    <= bus.sd_ack;
            eep_wr_r <= 1'b0;

            if (img_mounted) mounted <= img_size_nz;

            if (tmr_run)    timer <= timer - 24'd1;
            if (cpu_eep_wr) timer <= AUTOSAVE_CYCLES;

            case (state)
                IDLE: begin
                    if ((load_pend | save_pend) && !cpu_eep_busy) begin
                        state <= ARB;
                        own   <= 1'b1;
                    end
                end
                ARB: begin
                    blk     <= '0;
                    is_load <= load_pend;
                    if (load_pend) begin
                        state   <= LOAD_REQ;
                        sd_rd_r <= 1'b1;
                    end else begin
                        state   <= SAVE_REQ;
                        sd_wr_r <= 1'b1;
                    end
                end
                LOAD_REQ, SAVE_REQ: begin
                    if (bus.sd_ack) begin
                        sd_rd_r <= 1'b0;
                        sd_wr_r <= 1'b0;
                        state   <= is_load ? LOAD_XFER : SAVE_XFER;
                    end
                end
                LOAD_XFER, SAVE_XFER: begin
                    if (state == LOAD_XFER && bus.sd_buff_wr) begin
                        load_addr <= 17'({blk, bus.sd_buff_addr});
                        load_data <= bus.sd_buff_dout;
                        eep_wr_r  <= 1'b1;
                    end
                    if (ack_fall) begin
                        if (!last_blk) begin
                            blk   <= blk + 1'b1;
                            state <= is_load ? LOAD_REQ : SAVE_REQ;
                            if (is_load) sd_rd_r <= 1'b1;
                            else         sd_wr_r <= 1'b1;
                        end else begin
                            state <= IDLE;
                            own   <= 1'b0;
                            dirty <= 1'b0;
                            if (is_load) load_pend <= 1'b0;
                            else         save_pend <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Sets come last so they win over the end-of-transfer clears:
            // a CPU write or request landing on the final cycle is not lost.
            if (cpu_eep_wr) dirty <= 1'b1;
            if (img_mounted & img_size_nz & ~img_readonly) load_pend <= 1'b1;
            if ((save_req | tmr_exp) & save_ok)            save_pend <= 1'b1;
        end
    end

    assign cpu_hold            = own;
    assign busy                = own;
    assign bus.ext_eep_data_en = own;
    assign bus.sd_lba          = 32'(blk);
    assign bus.sd_rd           = sd_rd_r;
    assign bus.sd_wr           = sd_wr_r;
    assign bus.ext_eep_data_wr = eep_wr_r;
    assign bus.ext_eep_data_in = load_data;
    // Save reads follow hps_io's byte address directly; the EEPROM's own
    // output register supplies the one-cycle read latency.
    assign bus.ext_eep_addr    = save_xfer ? 17'({blk, bus.sd_buff_addr}) : load_addr;
    assign bus.ext_eep_data_rd = save_xfer;
    assign bus.sd_buff_din     = save_xfer ? bus.ext_eep_data_out : 8'h00;
endmodule
